// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial WIDTH-bit subtractor. It computes a - b one bit per clock, LSB
// first. Each bit goes through a two-stage half-subtractor chain:
//   stage 1: d1 = x ^ y,   b1 = ~x & y     (x = minuend bit, y = subtrahend bit)
//   stage 2: d  = d1 ^ bin, b2 = ~d1 & bin  (bin = borrow from previous bit)
// The borrow out (b1 | b2) is held in a flip-flop and feeds the next bit.
//
// Handshake: start is accepted in IDLE or DONE. busy is high for WIDTH cycles.
// After that, done pulses for one cycle with diff/borrow/zero valid. A start
// seen in the DONE cycle begins the next operation back-to-back.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   synchronous active-low reset
//   start   in   operation request, sampled when not busy
//   a       in   minuend    [WIDTH-1:0], sampled on the accepting edge
//   b       in   subtrahend [WIDTH-1:0], sampled on the accepting edge
//   busy    out  operation in progress
//   done    out  one-cycle completion pulse
//   diff    out  (a - b) mod 2^WIDTH, registered, held until next completion
//   borrow  out  final borrow out (a < b unsigned)
//   zero    out  diff == 0, registered together with diff
//
// WIDTH: legal range 2..32.
// -----------------------------------------------------------------------------

module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  // The counter reaches WIDTH at most, so clog2(WIDTH)+1 bits are enough.
  // It never wraps.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] a_sh_reg,   a_sh_next;
  logic [WIDTH-1:0] b_sh_reg,   b_sh_next;
  logic [WIDTH-1:0] res_sh_reg, res_sh_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic             borrow_ff_reg, borrow_ff_next;

  logic [WIDTH-1:0] diff_reg,   diff_next;
  logic             borrow_reg, borrow_next;
  logic             zero_reg,   zero_next;
  logic             busy_reg,   busy_next;
  logic             done_reg,   done_next;

  // Control decodes
  logic accept;    // new operation taken on this edge (IDLE or DONE)
  logic last_bit;  // this RUN edge processes the MSB

  assign accept   = start && (state_reg != RUN);
  assign last_bit = (state_reg == RUN) && (cnt_reg == LAST_BIT);

  // Two-stage half-subtractor cell for the current bit
  logic stage1_d, stage1_b;
  logic stage2_d, stage2_b;
  logic bit_borrow;

  half_subtractor u_stage1 (
    .x  (a_sh_reg[0]),
    .y  (b_sh_reg[0]),
    .d  (stage1_d),
    .bo (stage1_b)
  );

  half_subtractor u_stage2 (
    .x  (stage1_d),
    .y  (borrow_ff_reg),
    .d  (stage2_d),
    .bo (stage2_b)
  );

  // The two stage borrows cannot both be 1. OR is still the textbook merge.
  assign bit_borrow = stage1_b | stage2_b;

  // The result fills from the MSB end. After WIDTH shifts, the first (LSB)
  // difference bit sits in bit 0.
  logic [WIDTH-1:0] res_shifted;
  assign res_shifted = {stage2_d, res_sh_reg[WIDTH-1:1]};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // DONE lasts one cycle. A start here chains straight into RUN.
        state_next = start ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs and datapath next-values
  always_comb begin
    a_sh_next      = a_sh_reg;
    b_sh_next      = b_sh_reg;
    res_sh_next    = res_sh_reg;
    cnt_next       = cnt_reg;
    borrow_ff_next = borrow_ff_reg;
    diff_next      = diff_reg;
    borrow_next    = borrow_reg;
    zero_next      = zero_reg;
    busy_next      = 1'b0;
    done_next      = 1'b0;

    if (accept) begin
      a_sh_next      = a;
      b_sh_next      = b;
      res_sh_next    = '0;
      cnt_next       = '0;
      borrow_ff_next = 1'b0;
      busy_next      = 1'b1;
    end else if (state_reg == RUN) begin
      a_sh_next      = a_sh_reg >> 1;
      b_sh_next      = b_sh_reg >> 1;
      res_sh_next    = res_shifted;
      cnt_next       = cnt_reg + 1'b1;
      borrow_ff_next = bit_borrow;
      busy_next      = 1'b1;
      if (last_bit) begin
        // Publish the result. The visible outputs change only here.
        diff_next   = res_shifted;
        borrow_next = bit_borrow;
        zero_next   = ~|res_shifted;
        busy_next   = 1'b0;
        done_next   = 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      res_sh_reg    <= '0;
      cnt_reg       <= '0;
      borrow_ff_reg <= 1'b0;
      diff_reg      <= '0;
      borrow_reg    <= 1'b0;
      zero_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      a_sh_reg      <= a_sh_next;
      b_sh_reg      <= b_sh_next;
      res_sh_reg    <= res_sh_next;
      cnt_reg       <= cnt_next;
      borrow_ff_reg <= borrow_ff_next;
      diff_reg      <= diff_next;
      borrow_reg    <= borrow_next;
      zero_reg      <= zero_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign diff   = diff_reg;
  assign borrow = borrow_reg;
  assign zero   = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed bench for serial_subtractor. It uses a WIDTH=8 instance for the
// handshake and vector tests, and a WIDTH=4 instance for the full operand
// sweep. Inputs change 1 time unit after a rising edge. Outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow, zero;

  logic       start4;
  logic [3:0] a4, b4;
  logic       busy4, done4;
  logic [3:0] diff4;
  logic       borrow4, zero4;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_diff = 8'h00;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .zero   (zero)
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .busy   (busy4),
    .done   (done4),
    .diff   (diff4),
    .borrow (borrow4),
    .zero   (zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b need 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b need 0", done); end
    checks++; if (diff !== 8'h00)  begin errors++; $display("FAIL reset_diff: got %h need 00", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b need 0", borrow); end
    checks++; if (zero !== 1'b0)   begin errors++; $display("FAIL reset_zero: got %b need 0", zero); end
    checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++; $display("FAIL reset_w4: busy=%b done=%b need 0 0", busy4, done4);
    end
    $display("reset: busy=%b done=%b diff=%h borrow=%b zero=%b", busy, done, diff, borrow, zero);
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'h05, 8'h03, 8'h00, 8'hFF, 8'h80, 8'h00};
    logic [7:0] vb [6] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'h7F, 8'h01};
    logic [7:0] vd [6] = '{8'h02, 8'hFE, 8'h00, 8'hFE, 8'h01, 8'hFF};
    logic       vw [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       vz [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int busy_cnt;
    bit got_done;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 start = 1'b1; a = va[i]; b = vb[i];
      @(posedge clk); #1 start = 1'b0; a = 8'hAA; b = 8'h55;  // must not matter
      busy_cnt = 0; got_done = 0;
      for (int c = 0; c < 20 && !got_done; c++) begin
        @(negedge clk);
        if (done) got_done = 1;
        else if (busy) begin
          busy_cnt++;
          if (busy_cnt == 4) begin
            checks++; if (diff !== prev_diff) begin
              errors++; $display("FAIL vec%0d_diff_held: got %h need %h", i, diff, prev_diff);
            end
          end
        end
      end
      checks++; if (!got_done) begin errors++; $display("FAIL vec%0d_timeout: no done within 20 cycles", i); end
      checks++; if (busy_cnt != 8) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d need 8", i, busy_cnt); end
      checks++; if (diff !== vd[i]) begin errors++; $display("FAIL vec%0d_diff: got %h need %h", i, diff, vd[i]); end
      checks++; if (borrow !== vw[i]) begin errors++; $display("FAIL vec%0d_borrow: got %b need %b", i, borrow, vw[i]); end
      checks++; if (zero !== vz[i]) begin errors++; $display("FAIL vec%0d_zero: got %b need %b", i, zero, vz[i]); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_with_done: got %b need 0", i, busy); end
      $display("op a=%h b=%h -> diff=%h borrow=%b zero=%b busy_cycles=%0d", va[i], vb[i], diff, borrow, zero, busy_cnt);
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL vec%0d_done_pulse: got %b need 0", i, done); end
      prev_diff = vd[i];
    end
  endtask

  task automatic test_back_to_back();
    int busy_cnt;
    int extra_done;
    bit got_done;
    @(posedge clk); #1 start = 1'b1; a = 8'h20; b = 8'h05;
    @(posedge clk);  // first op accepted here; start stays high
    busy_cnt = 0; got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
      else if (busy) begin
        busy_cnt++;
        if (busy_cnt == 3) begin a = 8'h07; b = 8'h09; end
      end
    end
    checks++; if (!got_done) begin errors++; $display("FAIL b2b_first_timeout: no done"); end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL b2b_first_busy: got %0d need 8", busy_cnt); end
    checks++; if (diff !== 8'h1B || borrow !== 1'b0) begin
      errors++; $display("FAIL b2b_first_result: got %h/%b need 1b/0", diff, borrow);
    end
    $display("b2b op1 a=20 b=05 -> diff=%h borrow=%b", diff, borrow);
    @(posedge clk); #1 start = 1'b0;  // DONE-cycle edge took the second op
    @(negedge clk);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_reaccept: busy=%b done=%b need 1 0", busy, done);
    end
    busy_cnt = 1; got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
      else if (busy) busy_cnt++;
    end
    checks++; if (!got_done) begin errors++; $display("FAIL b2b_second_timeout: no done"); end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL b2b_second_busy: got %0d need 8", busy_cnt); end
    checks++; if (diff !== 8'hFE || borrow !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL b2b_second_result: got %h/%b/%b need fe/1/0", diff, borrow, zero);
    end
    $display("b2b op2 a=07 b=09 -> diff=%h borrow=%b", diff, borrow);
    extra_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) extra_done++;
    end
    checks++; if (extra_done != 0) begin
      errors++; $display("FAIL b2b_no_extra: got %0d busy/done cycles need 0", extra_done);
    end
    prev_diff = 8'hFE;
  endtask

  task automatic test_reset_abort();
    int done_seen;
    int busy_cnt;
    bit got_done;
    @(posedge clk); #1 start = 1'b1; a = 8'h55; b = 8'h11;
    @(posedge clk); #1 start = 1'b0;  // E0
    @(posedge clk); #1;               // E1
    @(posedge clk); #1;               // E2
    @(posedge clk); #1 rst_n = 1'b0;  // E3, reset sampled at E4
    @(posedge clk); #1 rst_n = 1'b1;  // E4
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: busy=%b done=%b need 0 0", busy, done);
    end
    checks++; if (diff !== 8'h00 || borrow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL abort_outputs: diff=%h borrow=%b zero=%b need 00 0 0", diff, borrow, zero);
    end
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses need 0", done_seen); end
    $display("abort: outputs cleared, done pulses after abort=%0d", done_seen);

    @(posedge clk); #1 start = 1'b1; a = 8'd10; b = 8'd4;
    @(posedge clk); #1 start = 1'b0;
    busy_cnt = 0; got_done = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      @(negedge clk);
      if (done) got_done = 1;
      else if (busy) busy_cnt++;
    end
    checks++; if (!got_done || busy_cnt != 8) begin
      errors++; $display("FAIL abort_restart_timing: done=%0d busy=%0d need 1 8", got_done, busy_cnt);
    end
    checks++; if (diff !== 8'd6 || borrow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL abort_restart_result: got %h/%b/%b need 06/0/0", diff, borrow, zero);
    end
    $display("op a=0a b=04 -> diff=%h borrow=%b busy_cycles=%0d", diff, borrow, busy_cnt);
    @(negedge clk);
  endtask

  task automatic test_sweep4();
    int busy_cnt;
    bit got_done;
    logic [3:0] exp_d;
    logic exp_b, exp_z;
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        exp_d = 4'(ai - bi);
        exp_b = (ai < bi);
        exp_z = (ai == bi);
        @(posedge clk); #1 start4 = 1'b1; a4 = 4'(ai); b4 = 4'(bi);
        @(posedge clk); #1 start4 = 1'b0;
        busy_cnt = 0; got_done = 0;
        for (int c = 0; c < 12 && !got_done; c++) begin
          @(negedge clk);
          if (done4) got_done = 1;
          else if (busy4) busy_cnt++;
        end
        checks++; if (!got_done || busy_cnt != 4) begin
          errors++; $display("FAIL sweep_timing a=%0d b=%0d: done=%0d busy=%0d need 1 4", ai, bi, got_done, busy_cnt);
        end
        checks++; if (diff4 !== exp_d || borrow4 !== exp_b || zero4 !== exp_z) begin
          errors++; $display("FAIL sweep_result a=%0d b=%0d: got %h/%b/%b need %h/%b/%b",
                             ai, bi, diff4, borrow4, zero4, exp_d, exp_b, exp_z);
        end
        $display("w4 a=%h b=%h -> diff=%h borrow=%b zero=%b", 4'(ai), 4'(bi), diff4, borrow4, zero4);
        @(negedge clk);
        checks++; if (done4 !== 1'b0) begin
          errors++; $display("FAIL sweep_done_pulse a=%0d b=%0d: got %b need 0", ai, bi, done4);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
    test_sweep4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
